// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Run-control sequencer for the 4-digit stopwatch/timer. It sits between the
// debounced button logic and the BCD digit counter chain. It turns the
// start/stop and clear pulses and the direction switch into the following:
//   - counter enables,
//   - counter init pulses,
//   - a latched count direction.
// When the terminal count is reached, it stops the count and drives a timed,
// blinking alarm.
//
// Parameters
//   BLINK_TICKS  deciClk ticks per alarm half-period (default 5 = 0.5 s)
//   ALARM_TICKS  deciClk ticks the alarm blinks before going quiet
//                (default 50 = 5 s), must be >= 1
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   start_stop  in   pulse: start / pause / resume, or silence the alarm
//   clear       in   pulse: back to IDLE and re-initialise the counters
//   up          in   direction switch (1 = count up, 0 = count down)
//   deciClk     in   0.1 s tick, at least 2 clk cycles apart
//   term        in   registered terminal-count flag from the detector
//   count_en    out  tick to the digit counters (combinational)
//   dir         out  latched direction for counters and terminal detector
//   clr_cnt     out  one-cycle pulse: zero all digits
//   load_cnt    out  one-cycle pulse: load the preset into all digits
//   running     out  high while in RUN
//   done        out  high while in DONE
//   alarm       out  blinking alarm drive
//
// Optional feature (macro LAP_HOLD_EN)
//   lap         in   pulse: toggles the display hold in RUN / PAUSE
//   freeze      out  display hold; the display latches the counters while high
//
// Pulse semantics: every control input (start_stop, clear, deciClk, lap) is a
// single-cycle strobe. It is acted on in exactly the cycle it is high, with no
// acknowledge and no back-pressure. The resulting state change is visible after
// the next rising clk edge. When several strobes arrive in the same cycle,
// clear outranks term, and term outranks start_stop.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int BLINK_TICKS = 5,
    parameter int ALARM_TICKS = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic start_stop,
    input  logic clear,
    input  logic up,
    input  logic deciClk,
    input  logic term,
`ifdef LAP_HOLD_EN
    input  logic lap,
    output logic freeze,
`endif
    output logic count_en,
    output logic dir,
    output logic clr_cnt,
    output logic load_cnt,
    output logic running,
    output logic done,
    output logic alarm
);

    // Counter widths hold 0 .. N-1, so no counter ever wraps before its limit.
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            init_pend;
    logic            init_req;
    logic            enter_done;
    logic            alarm_act;
    logic [BW-1:0]   blink_cnt;
    logic [AW-1:0]   total_cnt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (clear > term > start_stop)
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear)           state_next = IDLE;
                else if (start_stop) state_next = RUN;
            end
            RUN: begin
                if (clear)           state_next = IDLE;
                else if (term)       state_next = DONE;
                else if (start_stop) state_next = PAUSE;
            end
            PAUSE: begin
                // term is deliberately ignored while paused
                if (clear)           state_next = IDLE;
                else if (start_stop) state_next = RUN;
            end
            DONE: begin
                // start_stop only silences the alarm here
                if (clear)           state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        count_en   = 1'b0;
        init_req   = 1'b0;
        enter_done = 1'b0;
        // A tick that coincides with the start pulse is not counted, because
        // state is still IDLE/PAUSE. A tick that coincides with the pause pulse
        // is counted, because state is still RUN.
        count_en   = deciClk & (state == RUN);
        // A direction change in IDLE also re-initialises the counters, so
        // the display always starts from zero (up) or the preset (down).
        init_req   = clear | ((state == IDLE) & (up != dir));
        enter_done = (state_next == DONE) & (state != DONE);
    end

    // ------------------------------------------------------------------
    // Direction latch, init pulses, state decodes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            dir       <= 1'b1;
            init_pend <= 1'b1;
            clr_cnt   <= 1'b0;
            load_cnt  <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if ((state == IDLE) && (up != dir)) begin
                dir <= up;
            end
            // The pending request turns into one pulse on the next edge. A new
            // request made in the same cycle re-arms it, so a direction change
            // right after reset yields clr_cnt followed by load_cnt.
            init_pend <= init_req;
            clr_cnt   <= init_pend & dir;
            load_cnt  <= init_pend & ~dir;
            running   <= (state_next == RUN);
            done      <= (state_next == DONE);
        end
    end

    // ------------------------------------------------------------------
    // Alarm: blinks every BLINK_TICKS ticks for ALARM_TICKS ticks in DONE.
    // alarm_act marks the live blinking window. The alarm output itself is
    // low for half of every period, so alarm_act is needed to tell the low
    // half of a blink apart from the finished alarm.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm     <= 1'b0;
            alarm_act <= 1'b0;
            blink_cnt <= '0;
            total_cnt <= '0;
        end else if (enter_done) begin
            alarm     <= 1'b1;
            alarm_act <= 1'b1;
            blink_cnt <= '0;
            total_cnt <= '0;
        end else if ((state != DONE) || (state_next != DONE)) begin
            alarm     <= 1'b0;
            alarm_act <= 1'b0;
        end else if (start_stop) begin
            alarm     <= 1'b0;
            alarm_act <= 1'b0;
        end else if (deciClk && alarm_act) begin
            if (total_cnt == AW'(ALARM_TICKS - 1)) begin
                alarm     <= 1'b0;
                alarm_act <= 1'b0;
            end else begin
                total_cnt <= total_cnt + AW'(1);
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt <= '0;
                    alarm     <= ~alarm;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

`ifdef LAP_HOLD_EN
    // ------------------------------------------------------------------
    // Lap hold: only the display is frozen, and counting carries on.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze <= 1'b0;
        end else if ((state_next == IDLE) || (state_next == DONE)) begin
            freeze <= 1'b0;
        end else if (lap && ((state == RUN) || (state == PAUSE))) begin
            freeze <= ~freeze;
        end
    end
`endif

endmodule
